// File: rtl/unlock_sequencer_pkg.sv
// Shared definitions for the door-actuation stage: state codes and default timing constants.
package unlock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam int DEF_OPEN_TICKS    = 5;
  localparam int DEF_LOCKOUT_TICKS = 30;
  localparam int DEF_MAX_FAILS     = 3;
  localparam int DEF_TW            = 8;
  localparam int DEF_FW            = 2;

endpackage

// File: rtl/unlock_sequencer_tick_timer.sv
// Loadable down-counter paced by the tick enable; parks at zero and flags the 1->0 tick.
module tick_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic [TW-1:0] cnt,
  output logic          expire
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt    = r_cnt;
  assign expire = tick && (r_cnt == TW'(1));

endmodule

// File: rtl/unlock_sequencer.sv
// Door relay sequencer: timed open window, consecutive-failure count and timed lockout with alarm.
module unlock_sequencer
  import unlock_sequencer_pkg::*;
#(
  parameter int OPEN_TICKS    = DEF_OPEN_TICKS,
  parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
  parameter int MAX_FAILS     = DEF_MAX_FAILS,
  parameter int TW            = DEF_TW,
  parameter int FW            = DEF_FW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          unlock_pulse,
  input  logic          fail_pulse,
  input  logic          relock_pulse,
  output logic          door_open,
  output logic          alarm,
  output logic [FW-1:0] fail_cnt,
  output logic [TW-1:0] remaining
);

  localparam logic [TW-1:0] LD_OPEN    = TW'(OPEN_TICKS);
  localparam logic [TW-1:0] LD_LOCKOUT = TW'(LOCKOUT_TICKS);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAILS - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [FW-1:0] r_fail_cnt;
  logic [FW-1:0] w_fail_nxt;
  logic          r_door_open;
  logic          r_alarm;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_tick_en;
  logic          w_expire;
  logic [TW-1:0] w_cnt;

  tick_timer #(
    .TW(TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .load_val(w_load_val),
    .tick    (w_tick_en),
    .cnt     (w_cnt),
    .expire  (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_cnt;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_tick_en   = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (unlock_pulse) begin
          w_state_nxt = ST_OPEN;
          w_load      = 1'b1;
          w_load_val  = LD_OPEN;
          w_fail_nxt  = '0;
        end else if (fail_pulse) begin
          if (r_fail_cnt >= FAIL_LAST) begin
            w_state_nxt = ST_LOCKOUT;
            w_load      = 1'b1;
            w_load_val  = LD_LOCKOUT;
            w_fail_nxt  = FAIL_MAX;
          end else begin
            w_fail_nxt = r_fail_cnt + 1'b1;
          end
        end
      end
      ST_OPEN: begin
        // Load beats tick inside the timer, so tick can be forwarded unconditionally.
        w_tick_en = tick;
        if (relock_pulse) begin
          w_state_nxt = ST_LOCKED;
          w_load      = 1'b1;
          w_load_val  = '0;
        end else if (unlock_pulse) begin
          w_load     = 1'b1;
          w_load_val = LD_OPEN;
        end else if (w_expire) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKOUT: begin
        w_tick_en = tick;
        if (w_expire) begin
          w_state_nxt = ST_LOCKED;
          w_fail_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_load      = 1'b1;
        w_load_val  = '0;
        w_fail_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOCKED;
      r_fail_cnt  <= '0;
      r_door_open <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_cnt  <= w_fail_nxt;
      r_door_open <= (w_state_nxt == ST_OPEN);
      r_alarm     <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign door_open = r_door_open;
  assign alarm     = r_alarm;
  assign fail_cnt  = r_fail_cnt;
  assign remaining = w_cnt;

endmodule

// File: tb/tb_unlock_sequencer.sv
// Scoreboard bench for unlock_sequencer: directed scenarios then random pulses against a reference model.
module tb_unlock_sequencer;

  localparam int OPEN_T = 5;
  localparam int LOCK_T = 30;
  localparam int MAXF   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       unlock_pulse = 1'b0;
  logic       fail_pulse = 1'b0;
  logic       relock_pulse = 1'b0;
  logic       door_open;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic [7:0] remaining;

  int tests  = 0;
  int fails  = 0;
  int cycle  = 0;

  // Reference model: 0=locked, 1=open, 2=lockout
  int m_mode = 0;
  int m_fails = 0;
  int m_rem = 0;

  logic [11:0] exp_q[$];

  unlock_sequencer #(
    .OPEN_TICKS(OPEN_T), .LOCKOUT_TICKS(LOCK_T), .MAX_FAILS(MAXF), .TW(8), .FW(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .unlock_pulse(unlock_pulse),
    .fail_pulse(fail_pulse), .relock_pulse(relock_pulse), .door_open(door_open),
    .alarm(alarm), .fail_cnt(fail_cnt), .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model_out();
    return {(m_mode == 1), (m_mode == 2), 2'(m_fails), 8'(m_rem)};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_fails = 0; m_rem = 0;
  endfunction

  function automatic void model_step(bit u, bit f, bit r, bit t);
    if (m_mode == 0) begin
      if (u) begin
        m_mode = 1; m_rem = OPEN_T; m_fails = 0;
      end else if (f) begin
        m_fails = m_fails + 1;
        if (m_fails >= MAXF) begin
          m_fails = MAXF; m_mode = 2; m_rem = LOCK_T;
        end
      end
    end else if (m_mode == 1) begin
      if (r) begin
        m_mode = 0; m_rem = 0;
      end else if (u) begin
        m_rem = OPEN_T;
      end else if (t) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_mode = 0;
      end
    end else begin
      if (t) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode = 0; m_fails = 0;
        end
      end
    end
  endfunction

  function automatic void check(string name, logic [11:0] got, logic [11:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc %0d: got door=%b alarm=%b fcnt=%0d rem=%0d, want door=%b alarm=%b fcnt=%0d rem=%0d",
               name, cycle, got[11], got[10], got[9:8], got[7:0], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endfunction

  // Monitor: outputs are valid every cycle; compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) check("scoreboard", {door_open, alarm, fail_cnt, remaining}, exp_q.pop_front());
  end

  task automatic step(bit u, bit f, bit r, bit t, bit rst = 1'b0);
    @(negedge clk);
    unlock_pulse = u; fail_pulse = f; relock_pulse = r; tick = t; reset = rst;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(u, f, r, t);
    exp_q.push_back(model_out());
  endtask

  task automatic expect_now(string name, bit d, bit a, int fc, int rem);
    #2;
    check(name, {door_open, alarm, fail_cnt, remaining}, {d, a, 2'(fc), 8'(rem)});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 1'b1);
    expect_now("reset_state", 0, 0, 0, 0);

    // 1: unlock then five ticks close the door
    step(1, 0, 0, 0);
    expect_now("unlock_open", 1, 0, 0, 5);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    expect_now("open_expired", 0, 0, 0, 0);

    // 2: reload beats tick at remaining=2
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    expect_now("open_rem2", 1, 0, 0, 2);
    step(1, 0, 0, 1);
    expect_now("reload_beats_tick", 1, 0, 0, 5);

    // 3: relock wins over unlock
    step(1, 0, 1, 0);
    expect_now("relock_wins", 0, 0, 0, 0);

    // 4: three fails -> lockout; unlock ignored; expires after 30 ticks
    step(0, 1, 0, 0);
    expect_now("fail1", 0, 0, 1, 0);
    step(0, 1, 0, 1);
    expect_now("fail2", 0, 0, 2, 0);
    step(0, 1, 0, 0);
    expect_now("lockout_entry", 0, 1, 3, 30);
    step(1, 0, 0, 0);
    expect_now("lockout_ignores_unlock", 0, 1, 3, 30);
    for (int i = 0; i < 29; i++) step(0, 0, 0, 1);
    expect_now("lockout_rem1", 0, 1, 3, 1);
    step(0, 0, 0, 1);
    expect_now("lockout_done", 0, 0, 0, 0);

    // 5: unlock wins over simultaneous fail at fail_cnt=2
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    expect_now("unlock_over_fail", 1, 0, 0, 5);
    step(0, 0, 1, 0);

    // 6: asynchronous reset mid-lockout at remaining=17
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 1);
    expect_now("lockout_rem17", 0, 1, 3, 17);
    @(negedge clk);
    reset = 1'b1;
    expect_now("async_reset", 0, 0, 0, 0);
    model_reset();
    step(0, 0, 0, 0, 1'b1);
    step(1, 0, 0, 0);
    expect_now("unlock_after_reset", 1, 0, 0, 5);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 399) == 0);
    end

    step(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within bound");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
